// File: rtl/csa_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-select adder.
package csa_pkg;

  localparam int CSA_BLK_DEFAULT = 4;

  // Number of carry-select blocks (= pipeline stages).
  function automatic int csa_nblk(input int width, input int blk);
    return (blk > 0) ? width / blk : 1;
  endfunction

  function automatic bit csa_cfg_ok(input int width, input int blk);
    return (blk >= 1) && (width >= blk) && ((width % blk) == 0);
  endfunction

endpackage

// File: rtl/csa_blk.sv
// One combinational carry-select block: two ripple chains (carry-in 0 and 1)
// followed by a mux on the selected carry.
module csa_blk import csa_pkg::*; #(
  parameter int BLK = CSA_BLK_DEFAULT
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           csel,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK:0]   w_c0, w_c1;
  logic [BLK-1:0] w_s0, w_s1;

  always_comb begin
    // NOTE: every combinational variable gets a default first so no path infers a latch.
    w_c0    = '0;
    w_c1    = '0;
    w_c1[0] = 1'b1;
    w_s0    = '0;
    w_s1    = '0;
    for (int i = 0; i < BLK; i++) begin
      w_s0[i]   = a[i] ^ b[i] ^ w_c0[i];
      w_c0[i+1] = (a[i] & b[i]) | (w_c0[i] & (a[i] ^ b[i]));
      w_s1[i]   = a[i] ^ b[i] ^ w_c1[i];
      w_c1[i+1] = (a[i] & b[i]) | (w_c1[i] & (a[i] ^ b[i]));
    end
  end

  assign s  = csel ? w_s1 : w_s0;
  assign co = csel ? w_c1[BLK] : w_c0[BLK];

endmodule

// File: rtl/csa_pipe.sv
// Pipelined carry-select adder/subtractor, one stage per BLK-bit block, valid/ready on both sides.
// Define CSA_OVF_EN to add the registered signed-overflow output ovf.
module csa_pipe import csa_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int BLK   = CSA_BLK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = csa_nblk(WIDTH, BLK);

  if (!csa_cfg_ok(WIDTH, BLK)) begin : g_cfg_err
    $error("csa_pipe: WIDTH must be a positive multiple of BLK");
  end

  logic [NBLK-1:0]  r_valid;
  logic [NBLK-1:0]  r_carry;
  logic [WIDTH-1:0] r_sum [NBLK];
  logic [WIDTH-1:0] r_a   [NBLK];
  logic [WIDTH-1:0] r_b   [NBLK];

  logic             w_stall;
  logic             w_cin_eff;
  logic [WIDTH-1:0] w_b_eff;
  logic [NBLK-1:0]  w_valid_in;
  logic [NBLK-1:0]  w_csel;
  logic [NBLK-1:0]  w_blk_co;
  logic [WIDTH-1:0] w_sum_in [NBLK];
  logic [WIDTH-1:0] w_a_in   [NBLK];
  logic [WIDTH-1:0] w_b_in   [NBLK];
  logic [BLK-1:0]   w_blk_a  [NBLK];
  logic [BLK-1:0]   w_blk_b  [NBLK];
  logic [BLK-1:0]   w_blk_s  [NBLK];

  assign w_stall   = r_valid[NBLK-1] & ~out_ready;
  assign in_ready  = ~w_stall;
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub | cin;

  // Stage 0 takes its block and carry select from the ports; later stages from the previous stage.
  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_valid_in[k] = in_valid;
      assign w_csel[k]     = w_cin_eff;
      assign w_sum_in[k]   = '0;
      assign w_a_in[k]     = a;
      assign w_b_in[k]     = w_b_eff;
      assign w_blk_a[k]    = a[BLK-1:0];
      assign w_blk_b[k]    = w_b_eff[BLK-1:0];
    end else begin : g_next
      assign w_valid_in[k] = r_valid[k-1];
      assign w_csel[k]     = r_carry[k-1];
      assign w_sum_in[k]   = r_sum[k-1];
      assign w_a_in[k]     = r_a[k-1];
      assign w_b_in[k]     = r_b[k-1];
      assign w_blk_a[k]    = r_a[k-1][k*BLK +: BLK];
      assign w_blk_b[k]    = r_b[k-1][k*BLK +: BLK];
    end

    csa_blk #(.BLK(BLK)) u_blk (
      .a    (w_blk_a[k]),
      .b    (w_blk_b[k]),
      .csel (w_csel[k]),
      .s    (w_blk_s[k]),
      .co   (w_blk_co[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: data registers are cleared too, so sum/cout read 0 until the first result arrives.
    if (rst) begin
      r_valid <= '0;
      r_carry <= '0;
      for (int k = 0; k < NBLK; k++) begin
        r_sum[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
      end
    end else if (!w_stall) begin
      // NOTE: non-blocking updates let every stage capture its predecessor's pre-edge value.
      r_valid <= w_valid_in;
      r_carry <= w_blk_co;
      for (int k = 0; k < NBLK; k++) begin
        r_sum[k] <= w_sum_in[k] | (WIDTH'(w_blk_s[k]) << (k*BLK));
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
      end
    end
  end

  assign out_valid = r_valid[NBLK-1];
  assign sum       = r_sum[NBLK-1];
  assign cout      = r_carry[NBLK-1];

`ifdef CSA_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  logic r_ovf;
  logic w_msb_cin;

  assign w_msb_cin = w_blk_s[NBLK-1][BLK-1] ^ w_blk_a[NBLK-1][BLK-1] ^ w_blk_b[NBLK-1][BLK-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!w_stall) begin
      r_ovf <= w_msb_cin ^ w_blk_co[NBLK-1];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_csa_pipe.sv
// Self-checking bench for csa_pipe: directed vector table, handshake sequences and a
// randomized run scored against an arithmetic reference model.
module tb_csa_pipe;

  localparam int WIDTH = 16;
  localparam int BLK   = 4;
  localparam int NBLK  = WIDTH / BLK;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSA_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  res_t             exp_q[$];
  logic             hold_pending = 1'b0;
  logic [WIDTH-1:0] held_sum = '0;
  logic             held_cout = 1'b0;

  csa_pipe #(.WIDTH(WIDTH), .BLK(BLK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CSA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on the operands.
  function automatic res_t ref_calc(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                    input logic cin_i, input logic sub_i);
    res_t        r;
    longint      ua, ub, total;
    int          sres;
    ua = longint'(a_i);
    ub = longint'(b_i);
    if (sub_i) begin
      total  = ua - ub + 65536;
      r.cout = (ua >= ub);
      sres   = int'($signed(a_i)) - int'($signed(b_i));
    end else begin
      total  = ua + ub + longint'(cin_i);
      r.cout = (total >= 65536);
      sres   = int'($signed(a_i)) + int'($signed(b_i)) + int'(cin_i);
    end
    r.sum = WIDTH'(total % 65536);
    r.ovf = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic c, input logic s, input logic ordy);
    in_valid  = v;
    a         = aa;
    b         = bb;
    cin       = c;
    sub       = s;
    out_ready = ordy;
    #1;
  endtask

  // One clock of scoreboarded traffic: consume, hold-check, accept, then advance.
  task automatic cycle();
    res_t e;
    if (hold_pending) begin
      check("hold_valid", out_valid, 1);
      check("hold_sum", sum, held_sum);
      check("hold_cout", cout, held_cout);
    end
    hold_pending = out_valid && !out_ready;
    held_sum     = sum;
    held_cout    = cout;
    if (out_valid && out_ready) begin
      check("sb_expected_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_sum", sum, e.sum);
        check("sb_cout", cout, e.cout);
`ifdef CSA_OVF_EN
        check("sb_ovf", ovf, e.ovf);
`endif
      end
    end
    if (in_valid && in_ready) exp_q.push_back(ref_calc(a, b, cin, sub));
    step();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4*NBLK + 8 && exp_q.size() > 0; i++) cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    logic [WIDTH-1:0] corners [4];
    corners[0] = 16'h0000;
    corners[1] = 16'hFFFF;
    corners[2] = 16'h7FFF;
    corners[3] = 16'h8000;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return WIDTH'($urandom);
  endfunction

  initial begin
    vec_t vt [12];
    int   first, last, cnt;

    vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[2]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vt[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[5]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vt[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[8]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
    vt[9]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[10] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[11] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    // Reset state
    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef CSA_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    #2 rst = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1);

    // Directed vectors, one at a time, with latency measurement
    for (int i = 0; i < 12; i++) begin
      int lat;
      drive(1'b1, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 1'b1);
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        step();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, NBLK);
      check($sformatf("vec%0d_sum", i), sum, vt[i].sum);
      check($sformatf("vec%0d_cout", i), cout, vt[i].cout);
`ifdef CSA_OVF_EN
      check($sformatf("vec%0d_ovf", i), ovf, vt[i].ovf);
`endif
      step();
    end

    // Back-to-back: 8 transfers, then watch the output streak
    first = -1;
    last  = -1;
    cnt   = 0;
    for (int i = 0; i < 24; i++) begin
      if (i < 8) begin
        drive(1'b1, 16'(16'h1234 + i), 16'h0F0F, 1'b0, 1'b0, 1'b1);
        check("b2b_in_ready", in_ready, 1);
      end else begin
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      end
      if (out_valid) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
      cycle();
    end
    check("b2b_count", cnt, 8);
    check("b2b_contiguous", last - first, 7);
    check("b2b_first_latency", first, NBLK);
    check("b2b_empty", exp_q.size(), 0);

    // Backpressure: full pipeline stalled for 5 cycles, then drained
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom),
            !(i >= 6 && i < 11));
      if (i >= 6 && i < 11) check("bp_in_ready", in_ready, 0);
      cycle();
    end
    drain();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, pick_operand(), pick_operand(), 1'($urandom),
            1'($urandom), $urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Reset mid-operation with three results in flight
    hold_pending = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pick_operand(), pick_operand(), 1'b0, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step();
    check("mid_valid_before_rst", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    step();
    step();
    #2 rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) cnt++;
      step();
    end
    check("mid_no_stale_output", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_pipe.md
Name: csa_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor. Successor to the team's fixed 4-bit carry-select adder.
- Operands are split into NBLK = WIDTH/BLK blocks. Each block precomputes sums for carry-in 0 and 1, and the registered carry from the previous stage selects one.
- One pipeline stage per block, so throughput is one result per cycle.
- Valid/ready handshake on both sides. Sits in the datapath between operand registers and the ALU result mux.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of BLK.
- BLK, 4, bits per carry-select block; must be at least 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands presented this cycle
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  0 = a+b+cin; 1 = a-b, computed as a+~b+1
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out; in subtract mode, 1 means no borrow

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high. While rst=1, all valid bits, carries and data registers clear to 0, so out_valid=0, sum=0 and cout=0. in_ready=1 during and after reset.
- Stage structure: NBLK stages, stage k = 0..NBLK-1.
- Stage 0 registers:
  - block-0 sum, selected by cin_eff = sub ? 1 : cin;
  - block-0 carry-out;
  - a[WIDTH-1:BLK] and b_eff[WIDTH-1:BLK], where b_eff = sub ? ~b : b;
  - a valid bit.
- Stage k>0 computes block k from the held upper operands. Both candidates (carry 0 and carry 1) are formed combinationally; stage k-1's registered carry selects one. The stage forwards the lower sums and remaining upper operands.
- Latency: an accepted transfer (in_valid & in_ready) produces out_valid exactly NBLK cycles later if there is no stall. Default latency is 4.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - When stall=1, every stage register holds its value, including valid bits and bubbles.
  - When stall=0, all stages advance by one. A stage with valid=0 is a bubble; its data registers may update but its valid stays 0.
- Output hold: sum and cout are stable while out_valid=1 and out_ready=0. The output is consumed when out_valid & out_ready.
- Simultaneous events: with out_valid=1 and out_ready=1 the pipeline advances, and a new input is accepted in the same cycle. Full throughput is one per cycle.
- in_valid=0 while advancing inserts a bubble.
- Width rules: the result is modulo 2^WIDTH; cout is bit WIDTH of a + b_eff + cin_eff.
- BLK=WIDTH degenerates to a single stage with latency 1.
- Reset mid-operation: all in-flight results are discarded. No output appears for operands accepted before reset.

Optional Feature:
- Macro: CSA_OVF_EN.
- Defined: adds output port ovf (1 bit). ovf = carry into the MSB XOR cout, i.e. signed two's-complement overflow. It is registered with the final stage, resets to 0, and is aligned with out_valid and held during stall.
- Undefined: no ovf port and no associated logic.

Decomposition:
- Package csa_pkg: localparam function for NBLK (WIDTH/BLK); constant CSA_BLK_DEFAULT=4; elaboration-time check that WIDTH % BLK == 0.
- Sub-module csa_blk: purely combinational, parameter BLK. Inputs a, b, csel. Outputs s and co. Internally it holds two ripple chains, one with carry 0 and one with carry 1, followed by a mux on csel. Instantiated once per stage via a generate loop.

Test Plan:
- Reset, then a=16'hFFFF, b=16'h0001, cin=0, sub=0, in_valid=1 for one cycle -> exactly 4 cycles later out_valid=1, sum=16'h0000, cout=1.
- Subtract: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0. Then a=16'h0007, b=16'h0005 -> sum=16'h0002, cout=1.
- Back-to-back: 8 consecutive transfers with out_ready=1, values 16'h1234+i plus 16'h0F0F -> 8 consecutive out_valid cycles with in-order, correct sums, and in_ready never low.
- Backpressure: out_ready=0 for 5 cycles while the pipeline is full -> in_ready=0, sum and cout unchanged, no loss. Release -> the remaining results drain in order.
- Reset mid-operation: assert rst asynchronously with 3 results in flight -> out_valid=0 immediately, and no stale result appears after release.
- CSA_OVF_EN defined: a=16'h7FFF, b=16'h0001 -> ovf=1, sum=16'h8000. a=16'h8000, b=16'h0001, sub=1 -> ovf=1, sum=16'h7FFF.
